// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel position, display window and timing lock from an external hsync/vsync stream
module vga_sync_decoder #(
    parameter int HD          = 640,
    parameter int HTOTAL      = 800,
    parameter int HSYNC_START = 656,
    parameter int VD          = 480,
    parameter int VTOTAL      = 525,
    parameter int VSYNC_START = 513,
    parameter int LOCK_FRAMES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       p_tick,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines
);
    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
    state_t state, state_n;
    logic hs_q, vs_h, h_seen, v_seen, frame_bad;
    logic h_seen_n, v_seen_n, frame_bad_n;
    logic [9:0] tc, lc, x_n, y_n, tc_n, lc_n;
    logic [7:0] gf, gf_n;
    logic h_rise, v_rise, x_wrap, line_bad, lines_bad, timeout, err, restart;
    always_comb begin
        h_rise      = p_tick && hsync && !hs_q;
        v_rise      = h_rise && vsync && !vs_h;
        x_wrap      = x == 10'(HTOTAL - 1);
        x_n         = h_rise ? 10'(HSYNC_START) : x_wrap ? 10'd0 : x + 10'd1;
        y_n         = v_rise ? 10'(VSYNC_START) : !x_wrap || h_rise ? y : y == 10'(VTOTAL - 1) ? 10'd0 : y + 10'd1;
        tc_n        = h_rise ? 10'd1 : tc == 10'h3ff ? tc : tc + 10'd1;
        lc_n        = v_rise ? 10'd1 : h_rise && lc != 10'h3ff ? lc + 10'd1 : lc;
        line_bad    = h_rise && h_seen && tc != 10'(HTOTAL);
        lines_bad   = v_rise && v_seen && lc != 10'(VTOTAL);
        timeout     = p_tick && !h_rise && tc == 10'(TIMEOUT - 1);
        state_n     = state;
        gf_n        = gf;
        frame_bad_n = frame_bad;
        err         = 1'b0;
        case (state)
            SEARCH: begin
                if (v_rise) begin
                    state_n     = ACQUIRE;
                    gf_n        = 8'd0;
                    frame_bad_n = 1'b0;
                end
            end
            ACQUIRE: begin
                frame_bad_n = frame_bad || line_bad;
                if (v_rise) begin
                    frame_bad_n = 1'b0;
                    gf_n        = lines_bad || frame_bad || line_bad ? 8'd0 : gf + 8'd1;
                    if (gf_n >= 8'(LOCK_FRAMES)) state_n = LOCKED;
                end
            end
            LOCKED: begin
                if (line_bad || lines_bad) begin
                    err     = 1'b1;
                    state_n = SEARCH;
                end
            end
            default: state_n = SEARCH;
        endcase
        // a lost hsync restarts acquisition from any state; only a locked link reports it
        if (timeout) begin
            err     = state == LOCKED;
            state_n = SEARCH;
        end
        restart  = timeout || (state_n == SEARCH && state != SEARCH);
        h_seen_n = !restart && (h_seen || h_rise);
        v_seen_n = !restart && (v_seen || v_rise);
    end
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) state <= SEARCH;
        else state <= state_n;
    end
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            x           <= '0;
            y           <= '0;
            tc          <= '0;
            lc          <= '0;
            hs_q        <= 1'b0;
            vs_h        <= 1'b0;
            h_seen      <= 1'b0;
            v_seen      <= 1'b0;
            gf          <= '0;
            frame_bad   <= 1'b0;
            line_len    <= '0;
            frame_lines <= '0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_start <= p_tick && x_n == '0 && y_n == '0 && state_n == LOCKED;
            sync_err    <= err;
            if (p_tick) begin
                x           <= x_n;
                y           <= y_n;
                tc          <= tc_n;
                lc          <= lc_n;
                hs_q        <= hsync;
                vs_h        <= h_rise ? vsync : vs_h;
                h_seen      <= h_seen_n;
                v_seen      <= v_seen_n;
                gf          <= gf_n;
                frame_bad   <= frame_bad_n;
                line_len    <= h_rise && h_seen ? tc : line_len;
                frame_lines <= v_rise && v_seen ? lc : frame_lines;
            end
        end
    end
    assign locked   = state == LOCKED;
    assign video_on = locked && x < 10'(HD) && y < 10'(VD);
endmodule
